// File: rtl/snn_pkg.sv
// Shared types, default layer sizing and helpers for the spiking column layer.
package snn_pkg;

  localparam int NEURONS_DEF     = 16;
  localparam int TIME_PERIOD_DEF = 8;
  localparam int MAX_WINNERS_DEF = 4;

  localparam int TIME_W = $clog2(TIME_PERIOD_DEF);
  localparam int IDX_W  = $clog2(NEURONS_DEF);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    DONE   = 2'd2
  } wta_state_e;

  // A zero request still means one winner; requests above the implemented slot count saturate.
  function automatic int clamp_k(input int k, input int max_k);
    if (k < 1) return 1;
    if (k > max_k) return max_k;
    return k;
  endfunction

endpackage

// File: rtl/lowest_k_select.sv
// Combinational picker: admits the lowest-indexed candidates up to a limit and lists their indices.
module lowest_k_select
  import snn_pkg::*;
#(
  parameter int NEURONS     = NEURONS_DEF,
  parameter int MAX_WINNERS = MAX_WINNERS_DEF,
  localparam int I_W = $clog2(NEURONS),
  localparam int K_W = $clog2(MAX_WINNERS + 1)
) (
  input  logic [NEURONS-1:0]         cand,
  input  logic [K_W-1:0]             limit,
  output logic [NEURONS-1:0]         admit,
  output logic [MAX_WINNERS*I_W-1:0] idx,
  output logic [K_W-1:0]             count
);

  // Scan from neuron 0 upward so ties in the same tick go to the lower index.
  always_comb begin
    int taken;
    taken = 0;
    admit = '0;
    idx   = '0;
    for (int i = 0; i < NEURONS; i++) begin
      if (cand[i] && (taken < int'(limit)) && (taken < MAX_WINNERS)) begin
        admit[i] = 1'b1;
        idx[taken*I_W +: I_W] = I_W'(i);
        taken++;
      end
    end
    count = K_W'(taken);
  end

endmodule

// File: rtl/k_wta_inhibition.sv
// k-winner-take-all lateral inhibition for one column layer, one gamma cycle at a time.
//
//   state  | meaning
//   IDLE   | waiting for cycle_start; last results held on winner_*
//   ACTIVE | gamma cycle running; each step samples spikes and advances time_val
//   DONE   | one clk: result_valid high, winner_* final
module k_wta_inhibition
  import snn_pkg::*;
#(
  parameter int NEURONS     = NEURONS_DEF,
  parameter int TIME_PERIOD = TIME_PERIOD_DEF,
  parameter int MAX_WINNERS = MAX_WINNERS_DEF,
  localparam int T_W = $clog2(TIME_PERIOD),
  localparam int I_W = $clog2(NEURONS),
  localparam int K_W = $clog2(MAX_WINNERS + 1)
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       cycle_start,
  input  logic                       step,
  input  logic [K_W-1:0]             k_sel,
  input  logic [NEURONS-1:0]         spike_in,
  output logic [NEURONS-1:0]         spike_out,
  output logic [T_W-1:0]             time_val,
  output logic                       busy,
  output logic [NEURONS-1:0]         winner_mask,
  output logic [K_W-1:0]             winner_count,
  output logic [MAX_WINNERS*I_W-1:0] winner_idx,
  output logic [MAX_WINNERS*T_W-1:0] winner_time,
  output logic                       result_valid
);

  localparam logic [T_W-1:0] LAST_TICK = T_W'(TIME_PERIOD - 1);

  wta_state_e                 state, state_nxt;
  logic [K_W-1:0]             k_reg;
  logic [K_W-1:0]             free_slots;
  logic [K_W-1:0]             adm_count;
  logic [NEURONS-1:0]         cand;
  logic [NEURONS-1:0]         admit;
  logic [MAX_WINNERS*I_W-1:0] sel_idx;
  logic [MAX_WINNERS*I_W-1:0] idx_nxt;
  logic [MAX_WINNERS*T_W-1:0] time_nxt;
  logic                       last_tick;

  // Already-admitted neurons are masked out so a repeat spiker is never admitted twice.
  assign cand       = spike_in & ~winner_mask;
  assign free_slots = k_reg - winner_count;
  assign last_tick  = (time_val == LAST_TICK);
  assign busy         = (state == ACTIVE);
  assign result_valid = (state == DONE);

  lowest_k_select #(
    .NEURONS    (NEURONS),
    .MAX_WINNERS(MAX_WINNERS)
  ) u_select (
    .cand (cand),
    .limit(free_slots),
    .admit(admit),
    .idx  (sel_idx),
    .count(adm_count)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next state: cycle_start restarts from any state; the window always runs to its last tick.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (cycle_start) state_nxt = ACTIVE;
      ACTIVE: begin
        if (cycle_start)            state_nxt = ACTIVE;
        else if (step && last_tick) state_nxt = DONE;
      end
      DONE:    state_nxt = cycle_start ? ACTIVE : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // New winners append after the slots already filled, keeping admission order.
  always_comb begin
    idx_nxt  = winner_idx;
    time_nxt = winner_time;
    for (int s = 0; s < MAX_WINNERS; s++) begin
      for (int j = 0; j < MAX_WINNERS; j++) begin
        if ((j < int'(adm_count)) && (s == int'(winner_count) + j)) begin
          idx_nxt[s*I_W +: I_W]  = sel_idx[j*I_W +: I_W];
          time_nxt[s*T_W +: T_W] = time_val;
        end
      end
    end
  end

  // Datapath: clear and latch k on start, accumulate winners on each active step.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      spike_out    <= '0;
      time_val     <= '0;
      winner_mask  <= '0;
      winner_count <= '0;
      winner_idx   <= '0;
      winner_time  <= '0;
      k_reg        <= K_W'(1);
    end else begin
      spike_out <= '0;
      if (cycle_start) begin
        time_val     <= '0;
        winner_mask  <= '0;
        winner_count <= '0;
        winner_idx   <= '0;
        winner_time  <= '0;
        k_reg        <= K_W'(clamp_k(int'(k_sel), MAX_WINNERS));
      end else if ((state == ACTIVE) && step) begin
        spike_out    <= admit;
        winner_mask  <= winner_mask | admit;
        winner_count <= winner_count + adm_count;
        winner_idx   <= idx_nxt;
        winner_time  <= time_nxt;
        if (!last_tick) time_val <= time_val + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_k_wta_inhibition.sv
// Bench for k_wta_inhibition: directed gamma cycles against a queue-based reference model.
module tb_k_wta_inhibition;

  localparam int N  = 16;
  localparam int TP = 8;
  localparam int MW = 4;
  localparam int TW = 3;
  localparam int IW = 4;
  localparam int KW = 3;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          cycle_start;
  logic          step;
  logic [KW-1:0] k_sel;
  logic [N-1:0]  spike_in;
  logic [N-1:0]  spike_out;
  logic [TW-1:0] time_val;
  logic          busy;
  logic [N-1:0]  winner_mask;
  logic [KW-1:0] winner_count;
  logic [MW*IW-1:0] winner_idx;
  logic [MW*TW-1:0] winner_time;
  logic          result_valid;

  always #5 clk = ~clk;

  k_wta_inhibition dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .cycle_start (cycle_start),
    .step        (step),
    .k_sel       (k_sel),
    .spike_in    (spike_in),
    .spike_out   (spike_out),
    .time_val    (time_val),
    .busy        (busy),
    .winner_mask (winner_mask),
    .winner_count(winner_count),
    .winner_idx  (winner_idx),
    .winner_time (winner_time),
    .result_valid(result_valid)
  );

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  // Reference model: a gamma cycle is a list of (neuron, tick) winners in arrival order.
  bit           m_busy;
  bit           m_rv;
  int           m_time;
  int           m_k;
  int           q_idx[$];
  int           q_time[$];
  logic [N-1:0] m_spk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit is_winner(input int n);
    foreach (q_idx[s]) if (q_idx[s] == n) return 1'b1;
    return 1'b0;
  endfunction

  task automatic model_clock();
    int kk;
    m_spk = '0;
    m_rv  = 1'b0;
    if (!rst_n) begin
      m_busy = 1'b0;
      m_time = 0;
      m_k    = 1;
      q_idx.delete();
      q_time.delete();
    end else if (cycle_start) begin
      kk     = int'(k_sel);
      m_k    = (kk == 0) ? 1 : ((kk > MW) ? MW : kk);
      m_busy = 1'b1;
      m_time = 0;
      q_idx.delete();
      q_time.delete();
    end else if (m_busy && step) begin
      for (int n = 0; n < N; n++) begin
        if (spike_in[n] && !is_winner(n) && (q_idx.size() < m_k)) begin
          q_idx.push_back(n);
          q_time.push_back(m_time);
          m_spk[n] = 1'b1;
        end
      end
      if (m_time == TP - 1) begin
        m_busy = 1'b0;
        m_rv   = 1'b1;
      end else begin
        m_time++;
      end
    end
  endtask

  // Compare every output against the model once per clock, away from the rising edge.
  always @(negedge clk) begin
    if (chk_en) begin
      logic [N-1:0]     e_mask;
      logic [MW*IW-1:0] e_idx;
      logic [MW*TW-1:0] e_time;
      e_mask = '0;
      e_idx  = '0;
      e_time = '0;
      foreach (q_idx[s]) begin
        e_mask[q_idx[s]]   = 1'b1;
        e_idx[s*IW +: IW]  = IW'(q_idx[s]);
        e_time[s*TW +: TW] = TW'(q_time[s]);
      end
      chk("spike_out", spike_out, m_spk);
      chk("time_val", time_val, m_time);
      chk("busy", busy, m_busy);
      chk("result_valid", result_valid, m_rv);
      chk("winner_mask", winner_mask, e_mask);
      chk("winner_count", winner_count, q_idx.size());
      chk("winner_idx", winner_idx, e_idx);
      chk("winner_time", winner_time, e_time);
    end
  end

  task automatic cyc(input bit r, input bit cs, input bit st, input int k, input logic [N-1:0] spk);
    rst_n       = r;
    cycle_start = cs;
    step        = st;
    k_sel       = KW'(k);
    spike_in    = spk;
    model_clock();
    @(negedge clk);
    #1;
  endtask

  task automatic tick(input logic [N-1:0] spk);
    cyc(1'b1, 1'b0, 1'b1, 0, spk);
  endtask

  task automatic start(input int k);
    cyc(1'b1, 1'b1, 1'b0, k, '0);
  endtask

  task automatic idle();
    cyc(1'b1, 1'b0, 1'b0, 0, '0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    bit seen;
    rst_n = 1'b0; cycle_start = 1'b0; step = 1'b0; k_sel = '0; spike_in = '0;
    @(negedge clk);
    #1;
    cyc(1'b0, 1'b0, 1'b0, 0, '0);
    chk_en = 1'b1;
    chk("rst_busy", busy, 1'b0);
    chk("rst_count", winner_count, 0);
    chk("rst_idx", winner_idx, 0);

    // k=1: neurons 4,5 tie at tick 2, lower index wins; later spike suppressed.
    start(1);
    tick('0); tick('0);
    tick(16'h0030);
    chk("k1_spike_out", spike_out, 16'h0010);
    tick(16'h0001);
    chk("k1_suppressed", spike_out, 16'h0000);
    tick('0); tick('0); tick('0);
    chk("k1_not_done_yet", result_valid, 1'b0);
    tick('0);
    chk("k1_rv", result_valid, 1'b1);
    chk("k1_idx", winner_idx, 16'h0004);
    chk("k1_time", winner_time, 12'h002);
    chk("k1_mask", winner_mask, 16'h0010);
    idle();
    chk("k1_rv_pulse", result_valid, 1'b0);
    chk("k1_hold_idx", winner_idx, 16'h0004);

    // k=3: full volley at tick 0.
    start(3);
    tick(16'hFFFF);
    chk("k3_count", winner_count, 3);
    chk("k3_spike_out", spike_out, 16'h0007);
    chk("k3_idx", winner_idx, 16'h0210);
    chk("k3_time", winner_time, 12'h000);
    for (int t = 1; t < TP; t++) tick('0);
    chk("k3_rv", result_valid, 1'b1);

    // k=2: repeat spiker admitted once.
    start(2);
    tick('0); tick(16'h0100); tick('0); tick('0);
    tick(16'h0100);
    chk("k2_repeat", spike_out, 16'h0000);
    tick(16'h0002);
    chk("k2_second", spike_out, 16'h0002);
    tick('0); tick('0);
    chk("k2_idx", winner_idx, 16'h0018);
    chk("k2_time", winner_time, 12'h029);
    idle();

    // k_sel clamping.
    start(0);
    tick(16'h000F);
    chk("k0_count", winner_count, 1);
    chk("k0_mask", winner_mask, 16'h0001);
    for (int t = 1; t < TP; t++) tick('0);
    idle();
    start(7);
    tick(16'h00FF);
    chk("k7_count", winner_count, 4);
    chk("k7_idx", winner_idx, 16'h3210);
    tick(16'hFF00);
    chk("k7_full", spike_out, 16'h0000);
    for (int t = 2; t < TP; t++) tick('0);
    idle();

    // Abort mid-cycle, step gaps, start+step same clk.
    start(2);
    tick(16'h0040); tick('0); tick('0); tick('0);
    idle(); idle(); idle();
    chk("gap_time", time_val, 3'd4);
    cyc(1'b1, 1'b1, 1'b1, 2, 16'h0001);
    chk("abort_time", time_val, 3'd0);
    chk("abort_count", winner_count, 0);
    chk("abort_rv", result_valid, 1'b0);
    chk("abort_busy", busy, 1'b1);
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      tick(16'h0001);
      if (result_valid) seen = 1'b1;
    end
    chk("restart_rv_seen", seen, 1'b1);
    chk("restart_time", winner_time, 12'h000);
    idle();

    // Reset mid-ACTIVE with two winners latched; reset beats start/step.
    start(3);
    tick(16'h0003); tick('0);
    chk("pre_rst_count", winner_count, 2);
    cyc(1'b0, 1'b1, 1'b1, 3, 16'hFFFF);
    chk("midrst_busy", busy, 1'b0);
    chk("midrst_count", winner_count, 0);
    chk("midrst_mask", winner_mask, 16'h0000);
    chk("midrst_time", time_val, 3'd0);
    tick(16'h0001);
    chk("post_rst_idle", spike_out, 16'h0000);
    idle();

    chk_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
